// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared state encoding and command constants for the SPI slave
package spi_pkg;

    // Gray-coded so that every legal transition flips as few bits as possible
    typedef enum logic [2:0] {
        IDLE      = 3'b000,
        CHK_CMD   = 3'b001,
        WRITE     = 3'b011,
        READ_ADD  = 3'b010,
        READ_DATA = 3'b110,
        TX_WAIT   = 3'b111,
        TX_SHIFT  = 3'b101,
        DONE      = 3'b100
    } state_t;

    localparam logic [1:0] CMD_WR      = 2'b00;
    localparam logic [1:0] CMD_RD_ADD  = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_slave_param_if.sv
// rtl/spi_slave_param_if.sv - SPI pins plus read-reply and receive handshake bundle
interface spi_slave_param_if #(
    parameter int DATA_W = 8
);
    localparam int RX_W = DATA_W + 2;

    logic              SS_n;
    logic              MOSI;
    logic              tx_valid;
    logic [DATA_W-1:0] tx_data;
    logic              rx_valid;
    logic [RX_W-1:0]   rx_data;
    logic              MISO;
    logic              frame_err;
    logic              busy;

    modport slave (
        input  SS_n, MOSI, tx_valid, tx_data,
        output rx_valid, rx_data, MISO, frame_err, busy
    );

    modport master (
        output SS_n, MOSI, tx_valid, tx_data,
        input  rx_valid, rx_data, MISO, frame_err, busy
    );

endinterface

// File: rtl/spi_piso.sv
// rtl/spi_piso.sv - parallel-in serial-out shifter, MSB first
module spi_piso #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              shift,
    input  logic [DATA_W-1:0] din,
    output logic              dout
);

    logic [DATA_W-1:0] sr;

    // Load takes priority; each shift moves the next bit into the MSB position
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sr <= '0;
        end else if (load) begin
            sr <= din;
        end else if (shift) begin
            sr <= {sr[DATA_W-2:0], 1'b0};
        end
    end

    assign dout = sr[DATA_W-1];

endmodule

// File: rtl/spi_slave_param.sv
// rtl/spi_slave_param.sv - SPI slave with write, read-address and read-data transactions
module spi_slave_param
    import spi_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    spi_slave_param_if.slave bus
);

    localparam int RX_W  = DATA_W + 2;
    localparam int CNT_W = $clog2(RX_W + 1);
    localparam logic [CNT_W-1:0] LAST_RX = CNT_W'(RX_W - 1);
    localparam logic [CNT_W-1:0] LAST_TX = CNT_W'(DATA_W - 1);

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt;
    logic              rd_armed;
    logic              rd_armed_next;
    logic [RX_W-1:0]   rx_data;
    logic [RX_W-1:0]   rx_data_next;
    logic              rx_valid;
    logic              rx_valid_next;
    logic              frame_err;
    logic              frame_err_next;
    logic              piso_load;
    logic              piso_shift;
    logic              piso_out;
    logic [CNT_W-1:0]  rx_idx;
    logic [RX_W-1:0]   rx_sel;
    logic              rx_state;

    assign rx_state = (state == WRITE) || (state == READ_ADD) || (state == READ_DATA);

    // State, armed flag and registered output pulses
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            rd_armed  <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_next;
            rd_armed  <= rd_armed_next;
            rx_data   <= rx_data_next;
            rx_valid  <= rx_valid_next;
            frame_err <= frame_err_next;
        end
    end

    // Bit counter restarts on every state change and advances only while shifting
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (state_next != state) begin
            cnt <= '0;
        end else if (rx_state || state == TX_SHIFT) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Next-state logic; received bits land in place so unreceived bits keep old values
    always_comb begin
        state_next     = state;
        rd_armed_next  = rd_armed;
        rx_data_next   = rx_data;
        rx_valid_next  = 1'b0;
        frame_err_next = 1'b0;
        piso_load      = 1'b0;
        piso_shift     = 1'b0;
        rx_idx         = LAST_RX - cnt;
        rx_sel         = {{(RX_W-1){1'b0}}, 1'b1} << rx_idx;

        case (state)
            IDLE: begin
                if (!bus.SS_n) state_next = CHK_CMD;
            end
            CHK_CMD: begin
                if (bus.SS_n)          state_next = IDLE;
                else if (!bus.MOSI)    state_next = WRITE;
                else if (rd_armed)     state_next = READ_DATA;
                else                   state_next = READ_ADD;
            end
            WRITE, READ_ADD, READ_DATA: begin
                if (bus.SS_n) begin
                    state_next     = IDLE;
                    frame_err_next = 1'b1;
                end else begin
                    rx_data_next = bus.MOSI ? (rx_data | rx_sel) : (rx_data & ~rx_sel);
                    if (cnt == LAST_RX) begin
                        rx_valid_next = 1'b1;
                        state_next    = (state == READ_DATA) ? TX_WAIT : DONE;
                        if (state == READ_ADD) rd_armed_next = 1'b1;
                    end
                end
            end
            TX_WAIT: begin
                if (bus.SS_n) begin
                    state_next     = IDLE;
                    frame_err_next = 1'b1;
                    rd_armed_next  = 1'b0;
                end else if (bus.tx_valid) begin
                    piso_load  = 1'b1;
                    state_next = TX_SHIFT;
                end
            end
            TX_SHIFT: begin
                if (bus.SS_n) begin
                    state_next     = IDLE;
                    frame_err_next = 1'b1;
                    rd_armed_next  = 1'b0;
                end else begin
                    piso_shift = 1'b1;
                    if (cnt == LAST_TX) begin
                        state_next    = DONE;
                        rd_armed_next = 1'b0;
                    end
                end
            end
            DONE: begin
                if (bus.SS_n) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    spi_piso #(.DATA_W(DATA_W)) u_piso (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (piso_load),
        .shift (piso_shift),
        .din   (bus.tx_data),
        .dout  (piso_out)
    );

    assign bus.rx_valid  = rx_valid;
    assign bus.rx_data   = rx_data;
    assign bus.frame_err = frame_err;
    assign bus.busy      = (state != IDLE);
    assign bus.MISO      = (state == TX_SHIFT) && piso_out;

endmodule

// File: tb/tb_spi_slave_param.sv
// tb/tb_spi_slave_param.sv - directed bench for spi_slave_param at DATA_W 8 and 16
module tb_spi_slave_param;
    import spi_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        which = 1'b0;
    logic        ss = 1'b1;
    logic        mosi = 1'b0;
    logic        txv = 1'b0;
    logic [15:0] txd = '0;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    spi_slave_param_if #(.DATA_W(8))  ifc8 ();
    spi_slave_param_if #(.DATA_W(16)) ifc16 ();

    spi_slave_param #(.DATA_W(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(ifc8));
    spi_slave_param #(.DATA_W(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(ifc16));

    assign ifc8.SS_n      = which ? 1'b1 : ss;
    assign ifc8.MOSI      = mosi;
    assign ifc8.tx_valid  = which ? 1'b0 : txv;
    assign ifc8.tx_data   = txd[7:0];
    assign ifc16.SS_n     = which ? ss : 1'b1;
    assign ifc16.MOSI     = mosi;
    assign ifc16.tx_valid = which ? txv : 1'b0;
    assign ifc16.tx_data  = txd;

    logic        rx_valid_o, frame_err_o, busy_o, miso_o, armed_o;
    logic [17:0] rx_data_o;
    logic [2:0]  state_o;

    assign rx_valid_o  = which ? ifc16.rx_valid  : ifc8.rx_valid;
    assign frame_err_o = which ? ifc16.frame_err : ifc8.frame_err;
    assign busy_o      = which ? ifc16.busy      : ifc8.busy;
    assign miso_o      = which ? ifc16.MISO      : ifc8.MISO;
    assign rx_data_o   = which ? ifc16.rx_data   : {8'b0, ifc8.rx_data};
    assign state_o     = which ? dut16.state     : dut8.state;
    assign armed_o     = which ? dut16.rd_armed  : dut8.rd_armed;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_rx_valid"},  32'(rx_valid_o),  0);
        check({tag, "_rx_data"},   32'(rx_data_o),   0);
        check({tag, "_miso"},      32'(miso_o),      0);
        check({tag, "_frame_err"}, 32'(frame_err_o), 0);
        check({tag, "_busy"},      32'(busy_o),      0);
        check({tag, "_state"},     32'(state_o),     32'(IDLE));
        check({tag, "_armed"},     32'(armed_o),     0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ss    = 1'b1;
        txv   = 1'b0;
        tick();
        tick();
        check_idle_zero("reset");
        rst_n = 1'b1;
    endtask

    // Frame start: IDLE cycle, command bit in CHK_CMD, then nbits of word MSB first
    task automatic send_frame(input logic cmd, input logic [31:0] word, input int nbits, input int rxw);
        ss   = 1'b0;
        mosi = cmd;
        tick();
        tick();
        for (int i = 0; i < nbits; i++) begin
            mosi = word[rxw-1-i];
            check("bit_no_rx_valid", 32'(rx_valid_o), 0);
            check("bit_miso_low",    32'(miso_o),     0);
            tick();
        end
    endtask

    task automatic close_frame();
        ss = 1'b1;
        tick();
    endtask

    task automatic tx_phase(input logic [15:0] word, input int dw, input int wait_cycles);
        for (int i = 0; i < wait_cycles; i++) begin
            check("tx_wait_hold", 32'(state_o), 32'(TX_WAIT));
            check("tx_wait_miso", 32'(miso_o),  0);
            tick();
        end
        txv = 1'b1;
        txd = word;
        tick();
        txv = 1'b0;
        txd = '0;
        for (int i = dw - 1; i >= 0; i--) begin
            check("tx_miso_bit", 32'(miso_o), 32'(word[i]));
            tick();
        end
        check("tx_done_state", 32'(state_o), 32'(DONE));
        check("tx_done_armed", 32'(armed_o), 0);
        check("tx_done_miso",  32'(miso_o),  0);
    endtask

    initial begin
        // DATA_W = 8
        which = 1'b0;
        do_reset();

        send_frame(1'b0, 32'h0A5, 10, 10);
        check("wr_rx_valid", 32'(rx_valid_o), 1);
        check("wr_rx_data",  32'(rx_data_o),  32'h0A5);
        check("wr_state",    32'(state_o),    32'(DONE));
        mosi = 1'b1;
        tick();
        check("wr_pulse_one", 32'(rx_valid_o), 0);
        tick();
        check("done_ignores_mosi", 32'(rx_data_o), 32'h0A5);
        close_frame();
        check("wr_busy_low", 32'(busy_o), 0);

        send_frame(1'b1, 32'h23C, 10, 10);
        check("rdadd_rx_data", 32'(rx_data_o), 32'h23C);
        check("rdadd_armed",   32'(armed_o),   1);
        check("rdadd_state",   32'(state_o),   32'(DONE));
        close_frame();
        send_frame(1'b1, 32'h300, 10, 10);
        check("rddata_state",    32'(state_o),    32'(TX_WAIT));
        check("rddata_rx_valid", 32'(rx_valid_o), 1);
        check("rddata_rx_data",  32'(rx_data_o),  32'h300);
        tx_phase(16'h00C3, 8, 3);
        close_frame();

        send_frame(1'b0, 32'h3FF, 4, 10);
        close_frame();
        check("abort_wr_ferr",     32'(frame_err_o), 1);
        check("abort_wr_rx_valid", 32'(rx_valid_o),  0);
        check("abort_wr_busy",     32'(busy_o),      0);
        tick();
        check("abort_wr_ferr_pulse", 32'(frame_err_o), 0);

        send_frame(1'b0, 32'h155, 9, 10);
        mosi = 1'b1;
        close_frame();
        check("lastbit_ferr",     32'(frame_err_o), 1);
        check("lastbit_rx_valid", 32'(rx_valid_o),  0);
        check("lastbit_state",    32'(state_o),     32'(IDLE));
        tick();

        send_frame(1'b1, 32'h2AA, 10, 10);
        close_frame();
        send_frame(1'b1, 32'h300, 10, 10);
        txv = 1'b1;
        txd = 16'h00C3;
        tick();
        txv = 1'b0;
        tick();
        tick();
        tick();
        close_frame();
        check("abort_tx_ferr",  32'(frame_err_o), 1);
        check("abort_tx_armed", 32'(armed_o),     0);
        check("abort_tx_state", 32'(state_o),     32'(IDLE));
        ss   = 1'b0;
        mosi = 1'b1;
        tick();
        tick();
        check("after_abort_read_add", 32'(state_o), 32'(READ_ADD));
        close_frame();
        tick();

        // DATA_W = 16
        which = 1'b1;
        do_reset();

        send_frame(1'b0, 32'h0A5A5, 18, 18);
        check("w16_rx_valid", 32'(rx_valid_o), 1);
        check("w16_rx_data",  32'(rx_data_o),  32'h0A5A5);
        close_frame();

        send_frame(1'b1, 32'h21234, 18, 18);
        check("r16_armed", 32'(armed_o), 1);
        close_frame();
        send_frame(1'b1, 32'h30000, 18, 18);
        check("r16_state", 32'(state_o), 32'(TX_WAIT));
        tx_phase(16'hC35A, 16, 3);
        close_frame();

        send_frame(1'b1, 32'h20000, 18, 18);
        close_frame();
        send_frame(1'b1, 32'h3FFFF, 6, 18);
        check("mid_rd_state", 32'(state_o), 32'(READ_DATA));
        rst_n = 1'b0;
        tick();
        check_idle_zero("mid_reset");
        rst_n = 1'b1;
        ss    = 1'b1;
        tick();
        check("post_reset_ferr",     32'(frame_err_o), 0);
        check("post_reset_rx_valid", 32'(rx_valid_o),  0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_slave_param.md
SPI_SLAVE_PARAM -- requirements
Module: spi_slave_param

Interface
REQ-001 Parameter DATA_W, default 8: payload width in bits; legal range 4..32.
REQ-002 Parameter RX_W, fixed at DATA_W+2 (2 command bits + payload); not overridable.
REQ-003 clk  input  1  clock; all logic samples on the rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 SS_n  input  1  slave select, active-low; frames a transaction.
REQ-006 MOSI  input  1  serial data in, MSB first, one bit per clk.
REQ-007 tx_valid  input  1  tx_data is valid for a read reply.
REQ-008 tx_data  input  DATA_W  read reply word.
REQ-009 rx_valid  output  1  one-cycle pulse: rx_data holds a complete word.
REQ-010 rx_data  output  RX_W  received word {cmd[1:0], payload}.
REQ-011 MISO  output  1  serial data out, MSB first.
REQ-012 frame_err  output  1  one-cycle pulse: SS_n rose mid-word.
REQ-013 busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-014 FSM states SHALL be IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, TX_WAIT, TX_SHIFT and DONE.
REQ-015 IDLE->CHK_CMD when SS_n=0; otherwise IDLE is held.
REQ-016 CHK_CMD samples MOSI without capturing it: 0->WRITE; 1 with rd_armed=0->READ_ADD; 1 with rd_armed=1->READ_DATA.
REQ-017 WRITE, READ_ADD and READ_DATA each shift in exactly RX_W bits into rx_data, MSB first, over RX_W consecutive cycles.
REQ-018 rx_data bits not yet received in the current word SHALL hold the values they had before the word started.
REQ-019 rx_valid SHALL pulse for exactly one cycle, in the cycle after the RX_W-th bit is sampled.
REQ-020 rx_data SHALL stay stable from that rx_valid pulse until the next word starts.
REQ-021 WRITE and READ_ADD go to DONE after the word completes; READ_ADD completion also sets rd_armed=1.
REQ-022 READ_DATA goes to TX_WAIT after the word completes.
REQ-023 TX_WAIT holds until tx_valid=1, then captures tx_data into the shift register in that same cycle and goes to TX_SHIFT.
REQ-024 TX_SHIFT drives MISO with tx_data[DATA_W-1] down to tx_data[0], one bit per cycle, for DATA_W cycles.
REQ-025 After the last bit, TX_SHIFT goes to DONE and clears rd_armed.
REQ-026 MISO SHALL be 0 in every state except TX_SHIFT.
REQ-027 DONE holds until SS_n=1, then goes to IDLE; extra MOSI bits received in DONE are ignored.
REQ-028 SS_n=1 in CHK_CMD or DONE -> IDLE; no frame_err.
REQ-029 SS_n=1 while a word is partially shifted in, or in TX_WAIT or TX_SHIFT, -> IDLE with a frame_err pulse; no rx_valid in that case.
REQ-030 rd_armed is unchanged by an abort, except that aborting in TX_WAIT or TX_SHIFT clears it.
REQ-031 Bit counter width SHALL be $clog2(RX_W+1); counter returns to 0 on every state entry.
REQ-032 If SS_n rises in the same cycle as the last RX bit, the word is treated as aborted: frame_err pulses and rx_valid does not.

Reset
REQ-033 When rst_n=0 at a clk edge, state=IDLE, rd_armed=0, all counters=0 and all outputs=0, including rx_data.
REQ-034 Reset SHALL take effect mid-transaction without generating rx_valid or frame_err.

Structure
REQ-035 A shared package spi_pkg SHALL hold the state enum (gray-encoded, 3 bits) and the command constants CMD_WR=2'b00, CMD_RD_ADD=2'b10 and CMD_RD_DATA=2'b11.
REQ-036 The TX shifter SHALL be a sub-module spi_piso (load, shift, DATA_W-parameterised); the RX shifter is inline.

Verification
REQ-037 Reset then write: DATA_W=8, SS_n low, MOSI=0 then 10 bits 00_1010_0101 -> rx_valid one pulse 11 cycles after CHK_CMD, rx_data=10'h0A5, MISO=0 throughout.
REQ-038 Read address then read data: send 1 followed by 10'h2_3C -> rd_armed=1 -> new frame 1 followed by 10'h3_00 -> TX_WAIT.
REQ-039 Continuing REQ-038: tx_valid asserted 3 cycles late with tx_data=8'hC3 -> MISO=1,1,0,0,0,0,1,1 on consecutive cycles -> rd_armed=0.
REQ-040 Abort: SS_n raised after 4 bits of WRITE -> frame_err pulses once, rx_valid stays 0, busy=0 next cycle.
REQ-041 Abort in TX_SHIFT after 3 bits -> frame_err pulses and the next read frame enters READ_ADD.
REQ-042 Re-run REQ-037 and REQ-039 with DATA_W=16 and rst_n pulsed mid-READ_DATA -> all outputs 0, state IDLE, no pulses.
